// File: rtl/alu_control_unit.sv
// Single-cycle MIPS-subset execute/control core: the PC register, instruction
// decode, ALU, next-PC selection and register-file addressing/write-back muxes.
module alu_control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG = 5'd7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] mem_rd,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_next,
  output logic [4:0]  rf_a1,
  output logic [4:0]  rf_a2,
  output logic [4:0]  rf_a3,
  output logic        reg_write,
  output logic        mem_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump_reg,
  output logic        jump_link,
  output logic [4:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] wd3
);

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] pc_mux;

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign imm_ext = {{16{instr[15]}}, instr[15:0]};

  // PC is the only state; reset is asynchronous and restarts the program
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc <= RESET_PC;
    else          pc <= pc_next;
  end

  // Main decoder; unrecognised encodings fall through as a pc+4 no-op
  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    branch      = 1'b0;
    jump_reg    = 1'b0;
    jump_link   = 1'b0;
    alu_control = ALU_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_ADD; end
          FN_SUB: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_SUB; end
          FN_AND: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_AND; end
          FN_OR:  begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_OR;  end
          FN_SLT: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = ALU_SLT; end
          FN_JR:  jump_reg = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin alu_src = 1'b1; reg_write = 1'b1; end
      OP_LW:   begin alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      OP_SW:   begin alu_src = 1'b1; mem_write = 1'b1; end
      OP_BEQ:  begin branch = 1'b1; alu_control = ALU_SUB; end
      OP_JAL:  begin jump_link = 1'b1; reg_write = 1'b1; end
      default: ;
    endcase
  end

  assign src_b = alu_src ? imm_ext : rd2;

  always_comb begin
    alu_result = '0;
    unique case (alu_control)
      ALU_AND: alu_result = rd1 & src_b;
      ALU_OR:  alu_result = rd1 | src_b;
      ALU_ADD: alu_result = rd1 + src_b;
      ALU_SUB: alu_result = rd1 - src_b;
      ALU_SLT: alu_result = XLEN'($signed(rd1) < $signed(src_b));
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  assign pc_plus4      = pc + XLEN'(4);
  assign branch_target = pc_plus4 + {imm_ext[XLEN-3:0], 2'b00};
  assign pc_mux        = (branch && zero) ? branch_target : pc_plus4;

  always_comb begin
    if (jump_link)     pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (jump_reg) pc_next = rd1;
    else               pc_next = pc_mux;
  end

  assign rf_a1 = jump_reg ? LINK_REG : instr[25:21];
  assign rf_a2 = instr[20:16];

  always_comb begin
    if (jump_link)    rf_a3 = LINK_REG;
    else if (reg_dst) rf_a3 = instr[15:11];
    else              rf_a3 = instr[20:16];
  end

  always_comb begin
    if (jump_link)       wd3 = pc_plus4;
    else if (mem_to_reg) wd3 = mem_rd;
    else                 wd3 = alu_result;
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Scoreboard bench for alu_control_unit: stimulus pushes model expectations,
// a negedge monitor pops and compares every output of the cycle.
module tb_alu_control_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instr, rd1, rd2, mem_rd;
  logic [31:0] pc, pc_plus4, pc_next, alu_result, wd3;
  logic [4:0]  rf_a1, rf_a2, rf_a3, alu_control;
  logic        reg_write, mem_write, reg_dst, alu_src, mem_to_reg;
  logic        branch, jump_reg, jump_link, zero;

  alu_control_unit dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .rd1(rd1), .rd2(rd2),
    .mem_rd(mem_rd), .pc(pc), .pc_plus4(pc_plus4), .pc_next(pc_next),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .reg_write(reg_write),
    .mem_write(mem_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .branch(branch), .jump_reg(jump_reg),
    .jump_link(jump_link), .alu_control(alu_control), .alu_result(alu_result),
    .zero(zero), .wd3(wd3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc, pc_plus4, pc_next, alu_result, wd3, instr;
    logic [4:0]  a1, a2, a3, alu_control;
    logic        reg_write, mem_write, reg_dst, alu_src, mem_to_reg;
    logic        branch, jump_reg, jump_link, zero;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mpc;
  int          checks = 0;
  int          errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: classify the instruction by mnemonic, then apply its semantics
  function automatic exp_t model(input logic [31:0] p, input logic [31:0] i,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] m);
    exp_t e;
    string mn;
    logic [31:0] imm;
    mn = "nop";
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h20: mn = "add";
        6'h22: mn = "sub";
        6'h24: mn = "and";
        6'h25: mn = "or";
        6'h2A: mn = "slt";
        6'h08: mn = "jr";
        default: mn = "nop";
      endcase
    end else begin
      case (i[31:26])
        6'h08: mn = "addi";
        6'h23: mn = "lw";
        6'h2B: mn = "sw";
        6'h04: mn = "beq";
        6'h03: mn = "jal";
        default: mn = "nop";
      endcase
    end
    imm = {{16{i[15]}}, i[15:0]};
    e = '{default: '0};
    e.instr = i;
    e.pc = p;
    e.pc_plus4 = p + 32'd4;
    e.alu_control = 5'd2;
    e.alu_result = a + b;
    case (mn)
      "add":  begin e.reg_dst = 1; e.reg_write = 1; end
      "sub":  begin e.reg_dst = 1; e.reg_write = 1; e.alu_control = 5'd6; e.alu_result = a - b; end
      "and":  begin e.reg_dst = 1; e.reg_write = 1; e.alu_control = 5'd0; e.alu_result = a & b; end
      "or":   begin e.reg_dst = 1; e.reg_write = 1; e.alu_control = 5'd1; e.alu_result = a | b; end
      "slt":  begin e.reg_dst = 1; e.reg_write = 1; e.alu_control = 5'd7;
                    e.alu_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      "addi": begin e.alu_src = 1; e.reg_write = 1; e.alu_result = a + imm; end
      "lw":   begin e.alu_src = 1; e.mem_to_reg = 1; e.reg_write = 1; e.alu_result = a + imm; end
      "sw":   begin e.alu_src = 1; e.mem_write = 1; e.alu_result = a + imm; end
      "beq":  begin e.branch = 1; e.alu_control = 5'd6; e.alu_result = a - b; end
      "jal":  begin e.jump_link = 1; e.reg_write = 1; end
      "jr":   e.jump_reg = 1;
      default: ;
    endcase
    e.zero = (e.alu_result == 32'd0);
    if (mn == "jal")                e.pc_next = {e.pc_plus4[31:28], i[25:0], 2'b00};
    else if (mn == "jr")            e.pc_next = a;
    else if (mn == "beq" && e.zero) e.pc_next = e.pc_plus4 + imm * 4;
    else                            e.pc_next = e.pc_plus4;
    e.a1 = (mn == "jr") ? 5'd7 : i[25:21];
    e.a2 = i[20:16];
    e.a3 = (mn == "jal") ? 5'd7 : (e.reg_dst ? i[15:11] : i[20:16]);
    e.wd3 = (mn == "jal") ? e.pc_plus4 : ((mn == "lw") ? m : e.alu_result);
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one cycle of inputs at posedge+1 and queue the expected response
  task automatic issue(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] m);
    exp_t e;
    instr = i; rd1 = a; rd2 = b; mem_rd = m;
    e = model(mpc, i, a, b, m);
    sb.push_back(e);
    mpc = e.pc_next;
    @(posedge clock); #1;
  endtask

  // Monitor: all outputs are combinational-valid mid-cycle, compared at negedge
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("pc", pc, e.pc);
      cmp("pc_plus4", pc_plus4, e.pc_plus4);
      cmp("pc_next", pc_next, e.pc_next);
      cmp("rf_a1", 32'(rf_a1), 32'(e.a1));
      cmp("rf_a2", 32'(rf_a2), 32'(e.a2));
      cmp("rf_a3", 32'(rf_a3), 32'(e.a3));
      cmp("ctrl", {23'd0, reg_write, mem_write, reg_dst, alu_src, mem_to_reg,
                   branch, jump_reg, jump_link, zero},
                  {23'd0, e.reg_write, e.mem_write, e.reg_dst, e.alu_src, e.mem_to_reg,
                   e.branch, e.jump_reg, e.jump_link, e.zero});
      cmp("alu_control", 32'(alu_control), 32'(e.alu_control));
      cmp("alu_result", alu_result, e.alu_result);
      cmp("wd3", wd3, e.wd3);
      if (errors > 0 && errors < 4)
        $display("  context: instr=%h rd1=%h rd2=%h", e.instr, rd1, rd2);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a, b;
    int unsigned k;
    reset_n = 1'b0;
    instr = '0; rd1 = '0; rd2 = '0; mem_rd = '0;
    #1 cmp("reset_pc_initial", pc, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    mpc = 32'h0;

    issue(32'h0, 0, 0, 0);                                          // pc 0
    issue(32'h0, 0, 0, 0);                                          // pc 4
    issue(32'h0, 0, 0, 0);                                          // pc 8
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, 0);         // add -> 12
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h22), 32'd9, 32'd9, 0);         // sub -> zero
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h2A), 32'hFFFF_FFFF, 32'd1, 0); // slt -> 1
    issue(itype(6'h23, 5'd1, 5'd4, 16'hFFFC), 32'h100, 0, 32'hDEAD_BEEF);
    issue(itype(6'h2B, 5'd1, 5'd4, 16'hFFFC), 32'h100, 32'h55, 32'h1234);
    issue(rtype(5'd0, 5'd0, 5'd0, 6'h08), 32'h10, 0, 0);            // jr -> 0x10
    issue(itype(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'd3, 32'd3, 0);     // taken -> 0x0C
    issue(rtype(5'd0, 5'd0, 5'd0, 6'h08), 32'h10, 0, 0);
    issue(itype(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'd3, 32'd4, 0);     // not taken -> 0x14
    issue(rtype(5'd0, 5'd0, 5'd0, 6'h08), 32'h20, 0, 0);
    issue({6'h03, 26'h10}, 0, 0, 0);                                // jal -> 0x40
    cmp("pc_before_reset", pc, 32'h40);

    #2 reset_n = 1'b0;
    #1 cmp("reset_pc_async", pc, 32'h0);
    @(posedge clock); #1;
    cmp("reset_pc_held", pc, 32'h0);
    instr = 32'h0;
    reset_n = 1'b1;
    mpc = 32'h0;
    issue(32'h0, 0, 0, 0);
    issue(32'h0, 0, 0, 0);
    issue(32'h0, 0, 0, 0);
    issue(rtype(5'd3, 5'd0, 5'd0, 6'h08), 32'h24, 0, 0);            // jr via link -> 0x24

    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      k = $urandom_range(0, 11);
      case (k)
        0: r = {6'h00, r[25:6], 6'h20};
        1: r = {6'h00, r[25:6], 6'h22};
        2: r = {6'h00, r[25:6], 6'h24};
        3: r = {6'h00, r[25:6], 6'h25};
        4: r = {6'h00, r[25:6], 6'h2A};
        5: r = {6'h00, r[25:6], 6'h08};
        6: r = {6'h08, r[25:0]};
        7: r = {6'h23, r[25:0]};
        8: r = {6'h2B, r[25:0]};
        9: r = {6'h04, r[25:0]};
        10: r = {6'h03, r[25:0]};
        default: ;
      endcase
      issue(r, a, b, $urandom);
    end

    @(negedge clock); #1;
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
